// File: rtl/spi_byte_master_pkg.sv
// Shared SPI opcodes and FSM state encodings for the SPI byte master and its clients.
package spi_byte_master_pkg;

    localparam int W_SPI_MODE = 2;

    localparam logic [W_SPI_MODE-1:0] SPI_SEND    = 2'd1;
    localparam logic [W_SPI_MODE-1:0] SPI_RECEIVE = 2'd2;

    typedef enum logic [2:0] {
        SPI_ST_IDLE  = 3'd0,
        SPI_ST_SETUP = 3'd1,
        SPI_ST_SHIFT = 3'd2,
        SPI_ST_HOLD  = 3'd3,
        SPI_ST_DONE  = 3'd4
    } spi_state_e;

    function automatic logic is_spi_op(input logic [W_SPI_MODE-1:0] op);
        return (op == SPI_SEND) || (op == SPI_RECEIVE);
    endfunction

endpackage

// File: rtl/spi_byte_master_clk_gen.sv
// Half-bit timer: paces SETUP/HOLD and, while toggling is enabled, generates SCLK
// plus single-cycle rise/fall strobes aligned to the edge where SCLK changes.
module spi_clk_gen #(
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_toggle,
    output logic o_tick,
    output logic o_rise,
    output logic o_fall,
    output logic o_sclk
);

    localparam logic [7:0] HALF_LAST = 8'(CLKS_PER_HALF_BIT - 1);

    logic [7:0] r_cnt;
    logic       r_sclk;

    assign o_tick = i_run && (r_cnt == HALF_LAST);
    assign o_rise = o_tick && i_toggle && !r_sclk;
    assign o_fall = o_tick && i_toggle &&  r_sclk;
    assign o_sclk = r_sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 8'd0;
            r_sclk <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            if (!i_run || o_tick) begin
                r_cnt <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (!i_toggle) begin
                r_sclk <= 1'b0;
            end else if (o_tick) begin
                r_sclk <= !r_sclk;
            end
        end
    end

endmodule

// File: rtl/spi_byte_master.sv
// One-byte SPI mode-0 master, MSB first: SETUP (H) -> 8 SCLK periods (16H) -> HOLD (H) -> DONE.
module spi_byte_master
    import spi_byte_master_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W_SPI_MODE-1:0] control_rd,
    input  logic [7:0]            data_in,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            data_out,
    output logic                  dv_data_out,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n
);

    spi_state_e            r_state;
    spi_state_e            w_next;
    logic [W_SPI_MODE-1:0] r_mode;
    logic [7:0]            r_tx;
    logic [7:0]            r_rx;
    logic [7:0]            r_data_out;
    logic [2:0]            r_bit_cnt;

    logic w_accept;
    logic w_run;
    logic w_toggle;
    logic w_tick;
    logic w_rise;
    logic w_fall;
    logic w_sclk;

    assign w_accept = (r_state == SPI_ST_IDLE) && start && is_spi_op(control_rd);

    spi_clk_gen #(
        .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_run    (w_run),
        .i_toggle (w_toggle),
        .o_tick   (w_tick),
        .o_rise   (w_rise),
        .o_fall   (w_fall),
        .o_sclk   (w_sclk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SPI_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SPI_ST_IDLE:  if (w_accept) w_next = SPI_ST_SETUP;
            SPI_ST_SETUP: if (w_tick) w_next = SPI_ST_SHIFT;
            SPI_ST_SHIFT: if (w_fall && (r_bit_cnt == 3'd7)) w_next = SPI_ST_HOLD;
            SPI_ST_HOLD:  if (w_tick) w_next = SPI_ST_DONE;
            SPI_ST_DONE:  w_next = SPI_ST_IDLE;
            default:      w_next = SPI_ST_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        cs_n        = 1'b1;
        busy        = 1'b0;
        done        = 1'b0;
        dv_data_out = 1'b0;
        mosi        = 1'b0;
        w_run       = 1'b0;
        w_toggle    = 1'b0;
        case (r_state)
            SPI_ST_SETUP, SPI_ST_SHIFT, SPI_ST_HOLD: begin
                cs_n     = 1'b0;
                busy     = 1'b1;
                mosi     = r_tx[7];
                w_run    = 1'b1;
                w_toggle = (r_state == SPI_ST_SHIFT);
            end
            SPI_ST_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                dv_data_out = (r_mode == SPI_RECEIVE);
            end
            default: ;
        endcase
    end

    // Datapath: operands latched at acceptance, so later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= '0;
            r_tx       <= 8'h00;
            r_rx       <= 8'h00;
            r_data_out <= 8'h00;
            r_bit_cnt  <= 3'd0;
        end else begin
            if (w_accept) begin
                r_mode    <= control_rd;
                r_tx      <= (control_rd == SPI_SEND) ? data_in : 8'h00;
                r_bit_cnt <= 3'd0;
            end
            if (w_rise) begin
                r_rx <= {r_rx[6:0], miso};
            end
            if (w_fall) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt != 3'd7) begin
                    r_tx <= {r_tx[6:0], 1'b0};
                end
            end
            // Loaded on the HOLD->DONE edge so data_out is valid alongside dv_data_out.
            if ((r_state == SPI_ST_HOLD) && w_tick && (r_mode == SPI_RECEIVE)) begin
                r_data_out <= r_rx;
            end
        end
    end

    assign sclk     = w_sclk;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_spi_byte_master.sv
// Scoreboard bench for spi_byte_master: one instance at H=2 and one at H=5 behind a shared mux.
module tb_spi_byte_master;
    import spi_byte_master_pkg::*;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] mosi;
        logic [7:0] dout;
        int         cycles;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] control_rd;
    logic [7:0] data_in;
    logic       sel;
    logic       miso;
    logic [7:0] slave_byte;
    logic [2:0] fall_idx = 3'd7;
    logic [7:0] mosi_log;

    logic       a_start, a_busy, a_done, a_dv, a_sclk, a_mosi, a_cs_n;
    logic [7:0] a_dout;
    logic       b_start, b_busy, b_done, b_dv, b_sclk, b_mosi, b_cs_n;
    logic [7:0] b_dout;
    logic       m_busy, m_done, m_dv, m_sclk, m_mosi, m_cs_n;
    logic [7:0] m_dout;

    exp_t       sb_q[$];
    logic [7:0] model_dout [2];
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    assign a_start = start & ~sel;
    assign b_start = start &  sel;

    spi_byte_master #(.CLKS_PER_HALF_BIT(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .control_rd(control_rd), .data_in(data_in),
        .busy(a_busy), .done(a_done), .data_out(a_dout), .dv_data_out(a_dv),
        .sclk(a_sclk), .mosi(a_mosi), .miso(miso), .cs_n(a_cs_n)
    );

    spi_byte_master #(.CLKS_PER_HALF_BIT(5)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .control_rd(control_rd), .data_in(data_in),
        .busy(b_busy), .done(b_done), .data_out(b_dout), .dv_data_out(b_dv),
        .sclk(b_sclk), .mosi(b_mosi), .miso(miso), .cs_n(b_cs_n)
    );

    assign m_busy = sel ? b_busy : a_busy;
    assign m_done = sel ? b_done : a_done;
    assign m_dv   = sel ? b_dv   : a_dv;
    assign m_sclk = sel ? b_sclk : a_sclk;
    assign m_mosi = sel ? b_mosi : a_mosi;
    assign m_cs_n = sel ? b_cs_n : a_cs_n;
    assign m_dout = sel ? b_dout : a_dout;

    // Mode-0 slave: presents bit 7 while selected, advances on each SCLK falling edge.
    always @(negedge m_sclk or posedge m_cs_n) begin
        if (m_cs_n) fall_idx <= 3'd7;
        else        fall_idx <= fall_idx - 3'd1;
    end
    assign miso = slave_byte[fall_idx];

    always @(posedge m_sclk) mosi_log <= {mosi_log[6:0], m_mosi};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    endtask

    task automatic xfer(input logic use_b, input logic [1:0] mode, input logic [7:0] tx,
                        input logic [7:0] sbyte);
        exp_t e;
        int   h;
        bit   seen;
        logic lvl;
        int   lvl_len;
        bit   had_high;
        int   bad_phase;
        int   hi_runs;
        int   mosi_bad;
        int   dv_bad;
        h = use_b ? 5 : 2;
        @(negedge clk);
        sel        = use_b;
        slave_byte = sbyte;
        if (mode == SPI_RECEIVE) model_dout[use_b] = sbyte;
        e.mode   = mode;
        e.mosi   = (mode == SPI_SEND) ? tx : 8'h00;
        e.dout   = model_dout[use_b];
        e.cycles = 18 * h + 1;
        sb_q.push_back(e);
        control_rd = mode;
        data_in    = tx;
        start      = 1'b1;
        seen = 0; lvl = 1'b0; lvl_len = 0; had_high = 0;
        bad_phase = 0; hi_runs = 0; mosi_bad = 0; dv_bad = 0;
        for (int n = 1; n <= 400 && !seen; n++) begin
            @(negedge clk);
            if (m_sclk !== lvl) begin
                if (lvl) begin
                    hi_runs++;
                    had_high = 1;
                    if (lvl_len != h) bad_phase++;
                end else if (had_high && lvl_len != h) begin
                    bad_phase++;
                end
                lvl     = m_sclk;
                lvl_len = 1;
            end else begin
                lvl_len++;
            end
            if (mode == SPI_RECEIVE && m_mosi !== 1'b0) mosi_bad++;
            if (m_dv && !m_done) dv_bad++;
            if (m_done) begin
                seen = 1;
                e = sb_q.pop_front();
                chk("done_cycle", n, e.cycles);
                chk("mosi_bits", mosi_log, e.mosi);
                chk("data_out", m_dout, e.dout);
                chk("dv_data_out", m_dv, e.mode == SPI_RECEIVE);
                chk("busy_in_done", m_busy, 1);
            end
            if (n == 1) begin
                start      = 1'b0;
                data_in    = ~tx;
                control_rd = (mode == SPI_SEND) ? SPI_RECEIVE : SPI_SEND;
            end
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
            if (sb_q.size() > 0) e = sb_q.pop_front();
        end
        chk("sclk_phase_len", bad_phase, 0);
        chk("sclk_high_runs", hi_runs, 8);
        chk("dv_outside_done", dv_bad, 0);
        if (mode == SPI_RECEIVE) chk("mosi_quiet", mosi_bad, 0);
        @(negedge clk);
        chk("done_pulse_width", m_done, 0);
        chk("idle_after_done", {m_busy, m_cs_n}, 2'b01);
        chk("data_out_hold", m_dout, model_dout[use_b]);
    endtask

    initial begin
        logic [1:0] bad_codes [2];
        int         viol;
        int         rises, last_rise, period_bad, idle_cnt, gap_bad, dones;
        logic       prev_busy;
        bad_codes     = '{2'd0, 2'd3};
        start         = 1'b0;
        control_rd    = 2'd0;
        data_in       = 8'h00;
        sel           = 1'b0;
        slave_byte    = 8'h00;
        model_dout[0] = 8'h00;
        model_dout[1] = 8'h00;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", a_cs_n, 1);
        chk("rst_sclk", a_sclk, 0);
        chk("rst_mosi", a_mosi, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_dv", a_dv, 0);
        chk("rst_data_out", a_dout, 8'h00);
        chk("rst_b_cs_n", b_cs_n, 1);
        rst_n = 1'b1;
        @(negedge clk);

        xfer(1'b0, SPI_SEND,    8'hA5, 8'hFF);
        xfer(1'b0, SPI_RECEIVE, 8'h00, 8'h0F);
        xfer(1'b0, SPI_RECEIVE, 8'h5A, 8'hC3);
        xfer(1'b0, SPI_SEND,    8'h81, 8'h3E);

        foreach (bad_codes[k]) begin
            @(negedge clk);
            sel = 1'b0; control_rd = bad_codes[k]; start = 1'b1;
            viol = 0;
            repeat (50) begin
                @(negedge clk);
                if (a_busy !== 1'b0 || a_cs_n !== 1'b1 || a_done !== 1'b0) viol++;
            end
            start = 1'b0;
            chk("bad_code_ignored", viol, 0);
        end

        // start held high: accepted every 38 cycles with one IDLE cycle between transfers
        @(negedge clk);
        sel = 1'b0; slave_byte = 8'h69; control_rd = SPI_RECEIVE; start = 1'b1;
        prev_busy = 1'b0; rises = 0; last_rise = 0; period_bad = 0;
        idle_cnt = 0; gap_bad = 0; dones = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (a_busy && !prev_busy) begin
                if (rises > 0 && (n - last_rise) != 38) period_bad++;
                last_rise = n;
                rises++;
            end
            if (!a_busy && rises > 0) begin
                idle_cnt++;
                if (a_cs_n !== 1'b1) gap_bad++;
            end
            if (a_done) dones++;
            prev_busy = a_busy;
        end
        start = 1'b0;
        chk("held_accepts", rises, 6);
        chk("held_period", period_bad, 0);
        chk("held_idle_cycles", idle_cnt, 5);
        chk("held_idle_cs_n", gap_bad, 0);
        chk("held_dones", dones, 5);
        viol = 0;
        while (a_busy && viol < 100) begin
            @(negedge clk);
            viol++;
        end
        chk("held_drain", a_busy, 0);
        model_dout[0] = 8'h69;
        chk("held_data_out", a_dout, 8'h69);

        // asynchronous reset in the middle of a receive
        @(negedge clk);
        sel = 1'b0; slave_byte = 8'hAA; control_rd = SPI_RECEIVE; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_cs_n_active", a_cs_n, 0);
        chk("mid_sclk_high", a_sclk, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_cs_n", a_cs_n, 1);
        chk("abort_sclk", a_sclk, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_mosi", a_mosi, 0);
        viol = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_done || a_dv) viol++;
        end
        rst_n = 1'b1;
        model_dout[0] = 8'h00;
        model_dout[1] = 8'h00;
        repeat (40) begin
            @(negedge clk);
            if (a_done || a_dv || a_busy) viol++;
        end
        chk("abort_no_done", viol, 0);
        chk("abort_data_out", a_dout, 8'h00);
        xfer(1'b0, SPI_RECEIVE, 8'h00, 8'h96);

        xfer(1'b1, SPI_SEND,    8'h3C, 8'h00);
        xfer(1'b1, SPI_RECEIVE, 8'h00, 8'hB4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
